df_addsub_arbiter: RTL and testbench
====================================

// Module: df_addsub_arbiter
// PURPOSE
//   Shares one df_adder_subtractor (9-bit add/sub) between NUM_REQ filter-datapath
//   requesters. Round-robin grant, one operation accepted per cycle, registered result
//   tagged with the requester ID. Sits between the tap/accumulate stages and the shared unit.
// PARAMETERS
//   NUM_REQ  4  number of requesters (2..8)
//   DATA_W   9  operand/result width; must equal the df_adder_subtractor width
//   ID_W     2  requester-ID width; 2**ID_W >= NUM_REQ
// PORTS
//   clk        in   1               system clock, rising edge
//   reset      in   1               synchronous, active-high
//   req        in   NUM_REQ         per-requester request
//   req_a      in   NUM_REQ*DATA_W  operand a, requester i at [i*DATA_W +: DATA_W]
//   req_b      in   NUM_REQ*DATA_W  operand b, same packing
//   req_sub    in   NUM_REQ         1 = a-b, 0 = a+b
//   gnt        out  NUM_REQ         one-hot accept, combinational, same cycle as req
//   op_a       out  DATA_W          to shared unit operand a
//   op_b       out  DATA_W          to shared unit operand b
//   op_sub     out  1               to shared unit sub
//   op_out     in   DATA_W          from shared unit result
//   res_valid  out  1               result register holds unconsumed result
//   res_ready  in   1               consumer accepts result
//   res_data   out  DATA_W          registered result
//   res_id     out  ID_W            index of requester that produced res_data
// BEHAVIOUR
//   - Reset: res_valid=0, res_data=0, res_id=0, RR pointer=0, state=EMPTY.
//   - can_accept = !res_valid | res_ready. gnt=0 whenever !can_accept or req==0.
//   - Selection: first i with req[i]=1, searching from pointer upward, wrapping mod NUM_REQ.
//   - Granted cycle: op_a/op_b/op_sub = requester operands. Otherwise op_a=0, op_b=0, op_sub=0.
//   - On the edge ending a granted cycle: res_data<=op_out, res_id<=i, res_valid<=1, pointer<=(i+1) mod NUM_REQ.
//   - Latency: result visible 1 cycle after gnt. Throughput: 1 op/cycle while res_ready=1.
//   - FSM EMPTY (res_valid=0), FULL (res_valid=1):
//       EMPTY -> FULL on grant. EMPTY holds otherwise.
//       FULL & res_ready & grant -> FULL with new result (pipelined handoff).
//       FULL & res_ready & no grant -> EMPTY. FULL & !res_ready -> FULL, res_* held stable.
//   - Requester keeps req/operands stable until gnt. Dropping req before gnt is legal; no op issued.
//   - Pointer advances only on a grant. A lone requester is granted every accepting cycle.
//   - Arithmetic is modulo 2**DATA_W (wrap, no saturation), as in the shared unit.
//   - Reset mid-operation: pending result discarded, no gnt in the reset cycle.
// CONFIGURATION
//   DF_ARB_OVF_EN defined: extra output res_ovf (1 bit), registered with res_data, reset 0.
//     res_ovf = signed two's-complement overflow of the issued op:
//       add: a[MSB]==b[MSB] && out[MSB]!=a[MSB]; sub: a[MSB]!=b[MSB] && out[MSB]!=a[MSB].
//   DF_ARB_OVF_EN undefined: port res_ovf and its logic absent; all other behaviour identical.
// TESTING
//   1. Reset held 2 cycles with req=4'b1111 -> gnt=0, res_valid=0, res_data=0, res_id=0.
//   2. req[0] only, a=179 b=58 sub=0, res_ready=1 -> gnt=0001; next cycle res_data=237, res_id=0.
//   3. req[2] only, a=46 b=137 sub=1 -> res_data=421 (-91 mod 512), res_id=2.
//   4. req=1111 held, res_ready=1, 8 cycles -> gnt order 0,1,2,3,0,1,2,3; one result per cycle.
//   5. res_valid=1 with res_ready=0 for 3 cycles, req=0010 -> gnt=0, res_data/res_id stable.
//      res_ready=1 -> gnt=0010 same cycle, new result next cycle.
//   6. DF_ARB_OVF_EN: a=200 b=100 add -> res_data=300, res_ovf=1.
//      a=127 b=127 add -> res_data=254, res_ovf=0.

Source files
------------

// File: rtl/df_addsub_arbiter_if.sv
// Bundle between filter-datapath requesters, the shared add/sub unit and the result consumer.
// Optional res_ovf exists only when DF_ARB_OVF_EN is defined.
interface df_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_sub;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         op_a;
  logic [DATA_W-1:0]         op_b;
  logic                      op_sub;
  logic [DATA_W-1:0]         op_out;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_data;
  logic [ID_W-1:0]           res_id;
  logic                      dbg_state;
`ifdef DF_ARB_OVF_EN
  logic                      res_ovf;
`endif

  // Handshakes: req[i] is held with its operands until gnt[i] (dropping it earlier is legal);
  // a result transfers on any rising edge where res_valid && res_ready, and while res_valid=1
  // with res_ready=0 every res_* signal stays stable.
  modport slave (
    input  req, req_a, req_b, req_sub, op_out, res_ready,
    output gnt, op_a, op_b, op_sub, res_valid, res_data, res_id, dbg_state
`ifdef DF_ARB_OVF_EN
    , output res_ovf
`endif
  );

  modport master (
    output req, req_a, req_b, req_sub, op_out, res_ready,
    input  gnt, op_a, op_b, op_sub, res_valid, res_data, res_id, dbg_state
`ifdef DF_ARB_OVF_EN
    , input res_ovf
`endif
  );
endinterface

// File: rtl/df_addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit among NUM_REQ requesters; registered, ID-tagged result.
// Define DF_ARB_OVF_EN to add the registered signed-overflow flag res_ovf.
module df_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9,
  parameter int ID_W    = 2
) (
  input logic               clk,
  input logic               reset,
  df_addsub_arbiter_if.slave bus
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]         r_state;
  logic [DATA_W-1:0]  r_data;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_ptr;

  logic               w_can_accept;
  logic               w_grant;
  logic               w_hi_found;
  logic               w_lo_found;
  logic [ID_W-1:0]    w_hi_sel;
  logic [ID_W-1:0]    w_lo_sel;
  logic [ID_W-1:0]    w_sel;
  logic [ID_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0] w_gnt;
  logic [DATA_W-1:0]  w_op_a;
  logic [DATA_W-1:0]  w_op_b;
  logic               w_op_sub;

  // Two passes: first request at or above the pointer, else the lowest one (the wrap-around).
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && (ID_W'(i) >= r_ptr) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_sel   = ID_W'(i);
      end
      if (bus.req[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_sel   = ID_W'(i);
      end
    end
  end

  assign w_sel        = w_hi_found ? w_hi_sel : w_lo_sel;
  assign w_can_accept = (r_state == S_EMPTY) || bus.res_ready;
  assign w_grant      = !reset && w_can_accept && w_lo_found;
  assign w_ptr_next   = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);

  always_comb begin
    w_gnt    = '0;
    w_op_a   = '0;
    w_op_b   = '0;
    w_op_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant && (w_sel == ID_W'(i))) begin
        w_gnt[i] = 1'b1;
        w_op_a   = bus.req_a[i*DATA_W +: DATA_W];
        w_op_b   = bus.req_b[i*DATA_W +: DATA_W];
        w_op_sub = bus.req_sub[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_state <= S_FULL;
      r_data  <= bus.op_out;
      r_id    <= w_sel;
      r_ptr   <= w_ptr_next;
    end else if (bus.res_ready) begin
      r_state <= S_EMPTY;
    end
  end

`ifdef DF_ARB_OVF_EN
  logic r_ovf;
  logic w_ovf;
  localparam int MSB = DATA_W - 1;

  // Subtraction overflows when operand signs differ; addition when they match.
  assign w_ovf = (w_op_sub ? (w_op_a[MSB] != w_op_b[MSB]) : (w_op_a[MSB] == w_op_b[MSB]))
                 && (bus.op_out[MSB] != w_op_a[MSB]);

  always_ff @(posedge clk) begin
    if (reset)        r_ovf <= 1'b0;
    else if (w_grant) r_ovf <= w_ovf;
  end

  assign bus.res_ovf = r_ovf;
`endif

  assign bus.gnt       = w_gnt;
  assign bus.op_a      = w_op_a;
  assign bus.op_b      = w_op_b;
  assign bus.op_sub    = w_op_sub;
  assign bus.res_valid = (r_state == S_FULL);
  assign bus.res_data  = r_data;
  assign bus.res_id    = r_id;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_df_addsub_arbiter.sv
// Directed bench for df_addsub_arbiter; models the shared 9-bit add/sub unit on op_out.
// Overflow-flag checks compile in only when DF_ARB_OVF_EN is defined.
module tb_df_addsub_arbiter;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  df_addsub_arbiter_if #(.NUM_REQ(4), .DATA_W(9), .ID_W(2)) bus ();

  df_addsub_arbiter #(.NUM_REQ(4), .DATA_W(9), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.op_out = bus.op_sub ? (bus.op_a - bus.op_b) : (bus.op_a + bus.op_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [8:0] a, input logic [8:0] b, input logic s);
    bus.req_a[i*9 +: 9] = a;
    bus.req_b[i*9 +: 9] = b;
    bus.req_sub[i]      = s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 9'd1, 9'd1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
      @(posedge clk); #1;
      n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid); end
      n_tests++; if (bus.res_data !== 9'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", bus.res_data); end
      n_tests++; if (bus.res_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", bus.res_id); end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0000;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    bus.req = 4'b0001;
    set_op(0, 9'd179, 9'd58, 1'b0);
    #1;
    n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL add_gnt: got %b expected 0001", bus.gnt); end
    n_tests++; if (bus.op_a !== 9'd179) begin n_fail++; $display("FAIL add_op_a: got %0d expected 179", bus.op_a); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", bus.res_valid); end
    n_tests++; if (bus.res_data !== 9'd237) begin n_fail++; $display("FAIL add_data: got %0d expected 237", bus.res_data); end
    n_tests++; if (bus.res_id !== 2'd0) begin n_fail++; $display("FAIL add_id: got %0d expected 0", bus.res_id); end
  endtask

  task automatic test_single_sub();
    @(negedge clk);
    bus.req = 4'b0100;
    set_op(2, 9'd46, 9'd137, 1'b1);
    #1;
    n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL sub_gnt: got %b expected 0100", bus.gnt); end
    n_tests++; if (bus.op_sub !== 1'b1) begin n_fail++; $display("FAIL sub_op_sub: got %b expected 1", bus.op_sub); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_data !== 9'd421) begin n_fail++; $display("FAIL sub_data: got %0d expected 421", bus.res_data); end
    n_tests++; if (bus.res_id !== 2'd2) begin n_fail++; $display("FAIL sub_id: got %0d expected 2", bus.res_id); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.req = 4'b0001;
    set_op(0, 9'd179, 9'd58, 1'b0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.res_data !== 9'd237) begin n_fail++; $display("FAIL bp_first_data: got %0d expected 237", bus.res_data); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.req = 4'b0010;
      set_op(1, 9'd5, 9'd3, 1'b1);
      #1;
      n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL bp_gnt_stall: got %b expected 0000", bus.gnt); end
      @(posedge clk); #1;
      n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", bus.res_valid); end
      n_tests++; if (bus.res_data !== 9'd237) begin n_fail++; $display("FAIL bp_data_held: got %0d expected 237", bus.res_data); end
      n_tests++; if (bus.res_id !== 2'd0) begin n_fail++; $display("FAIL bp_id_held: got %0d expected 0", bus.res_id); end
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_gnt_release: got %b expected 0010", bus.gnt); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_data !== 9'd2) begin n_fail++; $display("FAIL bp_new_data: got %0d expected 2", bus.res_data); end
    n_tests++; if (bus.res_id !== 2'd1) begin n_fail++; $display("FAIL bp_new_id: got %0d expected 1", bus.res_id); end
    @(negedge clk);
    bus.req = 4'b0000;
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid: got %b expected 0", bus.res_valid); end
    n_tests++; if (bus.dbg_state !== 1'b0) begin n_fail++; $display("FAIL bp_drain_state: got %b expected 0", bus.dbg_state); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.req = 4'b1000;
    set_op(3, 9'd511, 9'd1, 1'b0);
    #1;
    n_tests++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_gnt: got %b expected 1000", bus.gnt); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_data !== 9'd0) begin n_fail++; $display("FAIL wrap_data: got %0d expected 0", bus.res_data); end
    n_tests++; if (bus.res_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id: got %0d expected 3", bus.res_id); end
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b expected 0000", bus.gnt); end
    n_tests++; if (bus.op_a !== 9'd0 || bus.op_sub !== 1'b0) begin n_fail++; $display("FAIL idle_ops: got op_a=%0d op_sub=%b expected 0 0", bus.op_a, bus.op_sub); end
  endtask

  task automatic test_ovf();
    @(negedge clk);
    bus.req = 4'b0010;
    set_op(1, 9'd200, 9'd100, 1'b0);
    @(posedge clk); #1;
    n_tests++; if (bus.res_data !== 9'd300) begin n_fail++; $display("FAIL ovf_add_data: got %0d expected 300", bus.res_data); end
`ifdef DF_ARB_OVF_EN
    n_tests++; if (bus.res_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_set: got %b expected 1", bus.res_ovf); end
`endif
    @(negedge clk);
    set_op(1, 9'd127, 9'd127, 1'b0);
    @(posedge clk); #1;
    n_tests++; if (bus.res_data !== 9'd254) begin n_fail++; $display("FAIL ovf_nodata: got %0d expected 254", bus.res_data); end
`ifdef DF_ARB_OVF_EN
    n_tests++; if (bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_clear: got %b expected 0", bus.res_ovf); end
`endif
    @(negedge clk);
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 9'(10 * (i + 1)), 9'(i + 1), 1'b0);
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus.res_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_gnt: got %b expected 0000", bus.gnt); end
    @(posedge clk); #1;
    n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.res_valid); end
    n_tests++; if (bus.res_data !== 9'd0) begin n_fail++; $display("FAIL mid_data: got %0d expected 0", bus.res_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt;
    logic [1:0] exp_id;
    logic [8:0] exp_data;
    // req=1111 with operands a_i=10(i+1), b_i=i+1 left by test_reset_mid; pointer is 0.
    for (int c = 0; c < 8; c++) begin
      exp_id   = 2'(c % 4);
      exp_gnt  = 4'b0001 << exp_id;
      exp_data = 9'(11 * (int'(exp_id) + 1));
      #1;
      n_tests++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_gnt); end
      @(posedge clk); #1;
      n_tests++; if (bus.res_valid !== 1'b1 || bus.res_id !== exp_id || bus.res_data !== exp_data) begin
        n_fail++;
        $display("FAIL rr_res[%0d]: got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d", c, bus.res_valid, bus.res_id, bus.res_data, exp_id, exp_data);
      end
      @(negedge clk);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sub = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single_add();
    test_single_sub();
    test_backpressure();
    test_wrap();
    test_ovf();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
